// File: rtl/s820_seq_harness.sv
// Sequential harness around the s820 combinational core: present-state register, vector/result handshakes.
// Optional scan chain on the state register when S820_SCAN_EN is defined.
module s820_seq_harness #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [4:0]  RESET_STATE   = 5'h00,
  parameter int unsigned CNT_W         = 16
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              vec_valid,
  output logic              vec_ready,
  input  logic [17:0]       vec_pi,
  output logic [17:0]       pi_q,
  output logic [4:0]        st_q,
  input  logic [4:0]        ns_d,
  input  logic [18:0]       po_d,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [18:0]       res_po,
  output logic [4:0]        res_state,
  output logic [CNT_W-1:0]  txn_cnt
`ifdef S820_SCAN_EN
  ,
  input  logic              scan_en,
  input  logic              scan_in,
  output logic              scan_out
`endif
);

  localparam int unsigned PI_W  = 18;
  localparam int unsigned ST_W  = 5;
  localparam int unsigned PO_W  = 19;
  localparam int unsigned SET_W = 4;

  typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, RESP} fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [SET_W-1:0] set_q, set_d;
  logic [PI_W-1:0]  pi_d;
  logic [ST_W-1:0]  st_d;
  logic [PO_W-1:0]  res_po_q, res_po_d;
  logic [ST_W-1:0]  res_state_q, res_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vec_ready_q, vec_ready_d;
  logic             res_valid_q, res_valid_d;
  logic             scan_en_c;

`ifdef S820_SCAN_EN
  assign scan_en_c = scan_en;
  assign scan_out  = st_q[0];
`else
  assign scan_en_c = 1'b0;
`endif

  // Next-state and next-output computation
  always_comb begin
    fsm_d       = fsm_q;
    set_d       = set_q;
    pi_d        = pi_q;
    st_d        = st_q;
    res_po_d    = res_po_q;
    res_state_d = res_state_q;
    cnt_d       = cnt_q;
    case (fsm_q)
      IDLE: begin
        if (scan_en_c) begin
`ifdef S820_SCAN_EN
          st_d = {scan_in, st_q[ST_W-1:1]};
`endif
        end else if (vec_valid && vec_ready_q) begin
          pi_d  = vec_pi;
          set_d = '0;
          fsm_d = APPLY;
        end
      end
      APPLY: begin
        if (set_q == SET_W'(SETTLE_CYCLES - 1)) begin
          set_d = '0;
          fsm_d = CAPTURE;
        end else begin
          set_d = set_q + SET_W'(1);
        end
      end
      CAPTURE: begin
        st_d        = ns_d;
        res_state_d = ns_d;
        res_po_d    = po_d;
        cnt_d       = cnt_q + CNT_W'(1);
        fsm_d       = RESP;
      end
      RESP: begin
        if (res_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
    // Handshake flags follow the state being entered so they are valid from the first cycle there
    vec_ready_d = (fsm_d == IDLE) && !scan_en_c;
    res_valid_d = (fsm_d == RESP);
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      fsm_q       <= IDLE;
      set_q       <= '0;
      pi_q        <= '0;
      st_q        <= RESET_STATE;
      res_po_q    <= '0;
      res_state_q <= RESET_STATE;
      cnt_q       <= '0;
      vec_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      set_q       <= set_d;
      pi_q        <= pi_d;
      st_q        <= st_d;
      res_po_q    <= res_po_d;
      res_state_q <= res_state_d;
      cnt_q       <= cnt_d;
      vec_ready_q <= vec_ready_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign vec_ready = vec_ready_q;
  assign res_valid = res_valid_q;
  assign res_po    = res_po_q;
  assign res_state = res_state_q;
  assign txn_cnt   = cnt_q;

endmodule

// File: tb/tb_s820_seq_harness.sv
// Scoreboard bench for s820_seq_harness with a stub core driving ns_d/po_d.
module tb_s820_seq_harness;

  localparam int unsigned CNT_W = 4;

  logic             CK = 1'b0;
  logic             RST;
  logic             vec_valid;
  logic             vec_ready;
  logic [17:0]      vec_pi;
  logic [17:0]      pi_q;
  logic [4:0]       st_q;
  logic [4:0]       ns_d;
  logic [18:0]      po_d;
  logic             res_valid;
  logic             res_ready;
  logic [18:0]      res_po;
  logic [4:0]       res_state;
  logic [CNT_W-1:0] txn_cnt;
`ifdef S820_SCAN_EN
  logic             scan_en;
  logic             scan_in;
  logic             scan_out;
`endif

  s820_seq_harness #(
    .SETTLE_CYCLES(1),
    .RESET_STATE  (5'h00),
    .CNT_W        (CNT_W)
  ) dut (
    .CK       (CK),
    .RST      (RST),
    .vec_valid(vec_valid),
    .vec_ready(vec_ready),
    .vec_pi   (vec_pi),
    .pi_q     (pi_q),
    .st_q     (st_q),
    .ns_d     (ns_d),
    .po_d     (po_d),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_po   (res_po),
    .res_state(res_state),
    .txn_cnt  (txn_cnt)
`ifdef S820_SCAN_EN
    ,
    .scan_en  (scan_en),
    .scan_in  (scan_in),
    .scan_out (scan_out)
`endif
  );

  always #5 CK = ~CK;

  typedef struct packed {
    logic [18:0]      po;
    logic [4:0]       st;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb[$];
  exp_t             mon_e;
  logic             mon_seen = 1'b0;
  logic [CNT_W-1:0] exp_cnt;
  int               total = 0;
  int               bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare the first cycle of each result against the scoreboard head
  always @(negedge CK) begin
    if (RST) begin
      mon_seen = 1'b0;
    end else if (res_valid && !mon_seen) begin
      mon_seen = 1'b1;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got res_valid=1 expected no result pending");
      end else begin
        mon_e = sb.pop_front();
        check("res_po",    32'(res_po),    32'(mon_e.po));
        check("res_state", 32'(res_state), 32'(mon_e.st));
        check("st_q",      32'(st_q),      32'(mon_e.st));
        check("txn_cnt",   32'(txn_cnt),   32'(mon_e.cnt));
      end
    end else if (!res_valid) begin
      mon_seen = 1'b0;
    end
  end

  // Offer one vector with the stub outputs set; returns cycles from accept to res_valid
  task automatic send(input logic [17:0] pi, input logic [4:0] ns, input logic [18:0] po,
                      input logic rdy, output int lat);
    int k;
    k = 0;
    @(negedge CK);
    while (!vec_ready && k < 50) begin
      @(negedge CK);
      k++;
    end
    lat = 0;
    if (!vec_ready) begin
      total++;
      bad++;
      $display("FAIL vec_ready_timeout: got vec_ready=0 expected 1 within 50 cycles");
    end else begin
      ns_d      = ns;
      po_d      = po;
      vec_pi    = pi;
      vec_valid = 1'b1;
      res_ready = rdy;
      @(posedge CK);
      sb.push_back({po, ns, exp_cnt + CNT_W'(1)});
      exp_cnt = exp_cnt + CNT_W'(1);
      #1 vec_valid = 1'b0;
      while (!res_valid && lat < 50) begin
        @(posedge CK);
        #1;
        lat++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [4:0]  bits;
    RST       = 1'b1;
    vec_valid = 1'b0;
    vec_pi    = '0;
    ns_d      = '0;
    po_d      = '0;
    res_ready = 1'b0;
    exp_cnt   = '0;
`ifdef S820_SCAN_EN
    scan_en   = 1'b0;
    scan_in   = 1'b0;
`endif

    // Reset held for two edges
    repeat (2) @(posedge CK);
    @(negedge CK);
    check("rst_st_q",      32'(st_q),      32'h00);
    check("rst_res_valid", 32'(res_valid), 32'h0);
    check("rst_vec_ready", 32'(vec_ready), 32'h0);
    check("rst_txn_cnt",   32'(txn_cnt),   32'h0);
    check("rst_pi_q",      32'(pi_q),      32'h0);
    RST = 1'b0;
    @(posedge CK);
    #1 check("post_rst_vec_ready", 32'(vec_ready), 32'h1);

    // Basic transaction
    send(18'h3_1234, 5'h15, 19'h2A5A5, 1'b1, lat);
    check("basic_latency", 32'(lat), 32'd2);
    check("basic_pi_q",    32'(pi_q), 32'h3_1234);

    // Backpressure with a changing stub
    send(18'h0_ABCD, 5'h0A, 19'h1_2345, 1'b0, lat);
    check("bp_latency", 32'(lat), 32'd2);
    for (int i = 0; i < 10; i++) begin
      @(negedge CK);
      ns_d      = 5'(i * 7 + 3);
      po_d      = 19'(i * 12345 + 1);
      vec_pi    = 18'(i * 999);
      vec_valid = 1'b1;
      @(posedge CK);
      #1;
      check("bp_res_state", 32'(res_state), 32'h0A);
      check("bp_res_po",    32'(res_po),    32'h1_2345);
      check("bp_st_q",      32'(st_q),      32'h0A);
      check("bp_vec_ready", 32'(vec_ready), 32'h0);
      check("bp_res_valid", 32'(res_valid), 32'h1);
      check("bp_pi_q",      32'(pi_q),      32'h0_ABCD);
    end
    @(negedge CK);
    vec_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge CK);
    #1 check("bp_release_valid", 32'(res_valid), 32'h0);
    check("bp_release_ready", 32'(vec_ready), 32'h1);
    check("bp_txn_cnt",       32'(txn_cnt),   32'h2);

    // Reset while in APPLY
    @(negedge CK);
    ns_d      = 5'h1F;
    po_d      = 19'h7_FFFF;
    vec_pi    = 18'h2_5555;
    vec_valid = 1'b1;
    @(posedge CK);
    #1 vec_valid = 1'b0;
    @(negedge CK);
    RST = 1'b1;
    @(posedge CK);
    #1 RST = 1'b0;
    exp_cnt = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CK);
      check("abort_res_valid", 32'(res_valid), 32'h0);
    end
    check("abort_st_q",    32'(st_q),    32'h00);
    check("abort_txn_cnt", 32'(txn_cnt), 32'h0);
    check("abort_pi_q",    32'(pi_q),    32'h0);

    // Seventeen transactions wrap the 4-bit counter
    for (int i = 1; i <= 17; i++) begin
      send(18'(i * 1111), 5'(i), 19'(i * 4321), 1'b1, lat);
    end
    @(posedge CK);
    #1 check("wrap_txn_cnt", 32'(txn_cnt), 32'h1);
    check("wrap_st_q", 32'(st_q), 32'h11);

`ifdef S820_SCAN_EN
    // Shift 5'b10110 in LSB first, then shift it back out
    bits = 5'b10110;
    for (int i = 0; i < 5; i++) begin
      @(negedge CK);
      scan_en = 1'b1;
      scan_in = bits[i];
      if (i == 2) check("scan_vec_ready", 32'(vec_ready), 32'h0);
    end
    @(negedge CK);
    check("scan_st_q", 32'(st_q), 32'h16);
    for (int i = 0; i < 5; i++) begin
      check("scan_out", 32'(scan_out), 32'(bits[i]));
      scan_in = 1'b0;
      @(negedge CK);
    end
    scan_en = 1'b0;
`else
    bits = 5'h0;
`endif

    @(negedge CK);
    check("sb_drained", 32'(sb.size()), 32'(bits & 5'h0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
